// File: rtl/spi_slave.sv
// ============================================================================
// Module   : spi_slave
// Brief    : Oversampled SPI peripheral, one byte in/out per 8 SCLK cycles.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpol,
    input  logic       cpha,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic [7:0] rx_data,
    output logic       done,
    output logic       busy,
    input  logic       SCLK,
    input  logic       MOSI,
    input  logic       SS_n,
    output logic       MISO
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic                   r_sclk_d;

    logic [0:0] r_state;
    logic [0:0] w_next_state;
    logic [3:0] r_bit_cnt;
    logic [6:0] r_rx_shift;
    logic [7:0] r_tx_shift;
    logic [7:0] r_rx_data;
    logic       r_done;
    logic       r_tx_load;

    logic w_sclk_s, w_mosi_s, w_ss_s;
    logic w_toggle, w_lead, w_trail, w_sample, w_shift;
    logic w_busy, w_miso;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_ss_sync   <= '0;
            r_sclk_d    <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SS_n};
            r_sclk_d    <= w_sclk_s;
        end
    end

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
    assign w_ss_s   = r_ss_sync[SYNC_STAGES-1];

    // Leading edge moves SCLK away from its idle level, trailing edge returns it.
    assign w_toggle = (w_sclk_s != r_sclk_d);
    assign w_lead   = w_toggle && (w_sclk_s != cpol);
    assign w_trail  = w_toggle && (w_sclk_s == cpol);
    assign w_sample = cpha ? w_trail : w_lead;
    assign w_shift  = cpha ? w_lead  : w_trail;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (!w_ss_s) w_next_state = ST_ACTIVE;
            ST_ACTIVE: if (w_ss_s)  w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        w_busy = (r_state == ST_ACTIVE);
        w_miso = w_busy ? r_tx_shift[7] : 1'b0;
    end

    // A completing sample is honoured even when deselect arrives in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt  <= 4'd0;
            r_rx_shift <= 7'd0;
            r_tx_shift <= 8'd0;
            r_rx_data  <= 8'd0;
            r_done     <= 1'b0;
            r_tx_load  <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_tx_load <= 1'b0;
            if (r_state == ST_IDLE) begin
                r_bit_cnt <= 4'd0;
                if (!w_ss_s) begin
                    r_tx_shift <= tx_data;
                    r_tx_load  <= 1'b1;
                end
            end else if (w_sample) begin
                r_rx_shift <= {r_rx_shift[5:0], w_mosi_s};
                if (r_bit_cnt == 4'd7) begin
                    r_rx_data  <= {r_rx_shift, w_mosi_s};
                    r_done     <= 1'b1;
                    r_bit_cnt  <= 4'd0;
                    r_tx_shift <= tx_data;
                    r_tx_load  <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end else if (w_shift && (r_bit_cnt != 4'd0)) begin
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            end
        end
    end

    assign tx_load = r_tx_load;
    assign rx_data = r_rx_data;
    assign done    = r_done;
    assign busy    = w_busy;
    assign MISO    = w_miso;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave.sv
// ============================================================================
// Module   : tb_spi_slave
// Brief    : Bit-banged SPI master bench; compares byte streams both ways.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spi_slave;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cpol = 1'b0;
    logic       cpha = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       SCLK = 1'b0;
    logic       MOSI = 1'b0;
    logic       SS_n = 1'b1;
    logic       tx_load, done, busy, MISO;
    logic [7:0] rx_data;

    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;
    int         load_cnt = 0;
    logic [7:0] rx_log[$];

    typedef struct {
        bit         pol;
        bit         pha;
        int         hp;
        logic [7:0] mo;
        logic [7:0] tx;
        logic [7:0] exp_rx;
        logic [7:0] exp_mi;
    } vec_t;

    vec_t tbl[5];

    spi_slave #(.SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset(reset), .cpol(cpol), .cpha(cpha),
        .tx_data(tx_data), .tx_load(tx_load), .rx_data(rx_data),
        .done(done), .busy(busy), .SCLK(SCLK), .MOSI(MOSI),
        .SS_n(SS_n), .MISO(MISO)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            rx_log.push_back(rx_data);
        end
        if (tx_load) load_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Master side: bytes are packed LSB-byte-first in mo/tx/mi, each sent MSB first.
    task automatic frame(input bit pol, input bit pha, input int hp, input int nbytes,
                         input int last_bits, input bit ss_on_edge,
                         input logic [31:0] mo, input logic [31:0] tx,
                         output logic [31:0] mi);
        mi   = '0;
        cpol = pol;
        cpha = pha;
        SCLK = pol;
        tick(SYNC + 4);
        tx_data = tx[7:0];
        SS_n = 1'b0;
        tick(hp);
        for (int k = 0; k < nbytes; k++) begin
            int nb;
            nb = (k == nbytes - 1) ? last_bits : 8;
            for (int b = 0; b < nb; b++) begin
                int i;
                bit fin;
                i   = 8 * k + 7 - b;
                fin = ss_on_edge && (k == nbytes - 1) && (b == nb - 1);
                if (!pha) begin
                    MOSI = mo[i];
                    tick(hp);
                    SCLK = ~pol;
                    if (fin) SS_n = 1'b1;
                    mi[i] = MISO;
                    tick(hp);
                    SCLK = pol;
                end else begin
                    SCLK = ~pol;
                    MOSI = mo[i];
                    tick(hp);
                    SCLK = pol;
                    if (fin) SS_n = 1'b1;
                    mi[i] = MISO;
                    tick(hp);
                end
                if (b == 0 && k + 1 < nbytes) tx_data = tx[8*(k+1) +: 8];
            end
        end
        tick(hp);
        SS_n = 1'b1;
        MOSI = 1'b0;
        tick(2 * SYNC + 6);
    endtask

    // Reference: the slave must receive exactly the master's bytes and return tx bytes.
    task automatic run_and_check(input string tag, input bit pol, input bit pha, input int hp,
                                 input int n, input bit ss_edge,
                                 input logic [31:0] mo, input logic [31:0] tx);
        int d0, l0, q0;
        logic [31:0] mi;
        d0 = done_cnt;
        l0 = load_cnt;
        q0 = rx_log.size();
        frame(pol, pha, hp, n, 8, ss_edge, mo, tx, mi);
        chk({tag, " done count"}, done_cnt - d0, n);
        chk({tag, " tx_load count"}, load_cnt - l0, n + 1);
        for (int k = 0; k < n; k++) begin
            chk({tag, " rx byte"}, (q0 + k < rx_log.size()) ? {24'd0, rx_log[q0+k]} : 32'hDEAD,
                {24'd0, mo[8*k +: 8]});
            chk({tag, " master rx byte"}, mi[8*k +: 8], tx[8*k +: 8]);
        end
        chk({tag, " rx_data"}, rx_data, mo[8*(n-1) +: 8]);
        chk({tag, " busy idle"}, busy, 1'b0);
    endtask

    initial begin
        logic [31:0] mi;
        int d0, l0;

        tbl[0] = '{0, 0, 50, 8'h3C, 8'hA5, 8'h3C, 8'hA5};
        tbl[1] = '{0, 1, 20, 8'h7E, 8'h81, 8'h7E, 8'h81};
        tbl[2] = '{1, 0, 20, 8'h7E, 8'h81, 8'h7E, 8'h81};
        tbl[3] = '{1, 1, 20, 8'h7E, 8'h81, 8'h7E, 8'h81};
        tbl[4] = '{0, 0, 6,  8'h00, 8'hFF, 8'h00, 8'hFF};

        tick(5);
        chk("reset rx_data", rx_data, 8'h00);
        chk("reset done", done, 1'b0);
        chk("reset tx_load", tx_load, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset MISO", MISO, 1'b0);
        reset = 1'b0;
        tick(10);

        for (int v = 0; v < 5; v++) begin
            d0 = done_cnt;
            l0 = load_cnt;
            frame(tbl[v].pol, tbl[v].pha, tbl[v].hp, 1, 8, 1'b0,
                  {24'd0, tbl[v].mo}, {24'd0, tbl[v].tx}, mi);
            chk("table rx_data", rx_data, tbl[v].exp_rx);
            chk("table master rx", mi[7:0], tbl[v].exp_mi);
            chk("table done count", done_cnt - d0, 1);
            chk("table tx_load count", load_cnt - l0, 2);
        end

        run_and_check("two bytes", 1'b0, 1'b0, 10, 2, 1'b0, 32'h3412, 32'h0FF0);

        d0 = done_cnt;
        frame(1'b0, 1'b0, 8, 1, 5, 1'b0, 32'hFF, 32'hA0, mi);
        chk("abort done count", done_cnt - d0, 0);
        chk("abort rx_data held", rx_data, 8'h34);
        chk("abort busy", busy, 1'b0);
        chk("abort MISO", MISO, 1'b0);
        run_and_check("after abort", 1'b0, 1'b0, 8, 1, 1'b0, 32'h55, 32'h3B);

        cpol = 1'b0;
        cpha = 1'b0;
        SCLK = 1'b0;
        tick(6);
        tx_data = 8'h99;
        SS_n = 1'b0;
        tick(8);
        for (int b = 0; b < 3; b++) begin
            MOSI = 1'b1;
            tick(8);
            SCLK = 1'b1;
            tick(8);
            SCLK = 1'b0;
        end
        tick(SYNC + 3);
        chk("busy before reset", busy, 1'b1);
        chk("MISO before reset", MISO, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("midframe reset rx_data", rx_data, 8'h00);
        chk("midframe reset busy", busy, 1'b0);
        chk("midframe reset MISO", MISO, 1'b0);
        chk("midframe reset done", done, 1'b0);
        chk("midframe reset tx_load", tx_load, 1'b0);
        tick(3);
        SS_n = 1'b1;
        MOSI = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(10);
        run_and_check("after reset", 1'b0, 1'b0, 8, 1, 1'b0, 32'hC3, 32'h5A);

        run_and_check("ss edge mode0", 1'b0, 1'b0, 8, 1, 1'b1, 32'h9A, 32'h6D);
        run_and_check("ss edge mode3", 1'b1, 1'b1, 8, 2, 1'b1, 32'hE74B, 32'h19C2);

        for (int r = 0; r < 8; r++) begin
            run_and_check("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(5, 12)), int'($urandom_range(1, 3)), 1'b0,
                          $urandom, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_slave.md
# spi_slave

SPI peripheral-side (slave) transceiver that pairs with the team's SPI master. Oversamples SCLK, MOSI and SS_n on the system clock, shifts one byte in on MOSI and one byte out on MISO per 8 SCLK cycles in any CPOL/CPHA mode, and reports each completed byte with a one-cycle `done` pulse. Sits at the chip's external SPI pins; the user side is a byte-parallel interface.

## Interface
- SYNC_STAGES, 2: synchronizer flops on SCLK, MOSI, SS_n (≥2).
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- cpol  input  1  SCLK idle level; static while SS_n low.
- cpha  input  1  0 = sample on leading edge, 1 = sample on trailing edge; static while SS_n low.
- tx_data  input  8  byte to transmit; captured on each `tx_load`.
- tx_load  output  1  one-cycle pulse: tx_data captured into the TX shift register this cycle.
- rx_data  output  8  last completely received byte; held until the next completion.
- done  output  1  one-cycle pulse: rx_data updated this cycle.
- busy  output  1  high while in ACTIVE.
- SCLK  input  1  serial clock from master (asynchronous to clk).
- MOSI  input  1  serial data from master.
- SS_n  input  1  active-low select.
- MISO  output  1  serial data to master; tx_shift[7] while selected, 0 while deselected.

## Operation
- Synchronized signals sclk_s, mosi_s, ss_s; sclk_d is sclk_s delayed one clk. Edge detect: lead = (sclk_s != sclk_d) && (sclk_s != cpol); trail = (sclk_s != sclk_d) && (sclk_s == cpol).
- sample_edge = cpha ? trail : lead; shift_edge = cpha ? lead : trail.
- States: IDLE, ACTIVE.
- IDLE: bit_cnt = 0, busy = 0. When ss_s == 0: tx_shift <= tx_data, tx_load = 1, go ACTIVE.
- ACTIVE, sample_edge: rx_shift <= {rx_shift[6:0], mosi_s}; bit_cnt += 1.
- ACTIVE, shift_edge with bit_cnt != 0: tx_shift <= {tx_shift[6:0], 1'b0}. With bit_cnt == 0, the edge is ignored; this covers the first leading edge of a byte in CPHA=1 and the trailing edge after the last sample in CPHA=0.
- Byte completion: on the sample_edge that makes bit_cnt reach 8:
  - rx_data <= {rx_shift[6:0], mosi_s}, done = 1.
  - bit_cnt <= 0; tx_shift <= tx_data, tx_load = 1.
  - Stay ACTIVE. Back-to-back bytes with no SS_n toggle are supported.
- ss_s rises in ACTIVE: go IDLE.
  - Partial byte (bit_cnt 1..7) is discarded: no done, rx_data unchanged.
  - If completion and ss_s rise happen in the same cycle, completion takes effect (done = 1, rx_data updated), then the state goes IDLE.
- bit_cnt is 4 bits, range 0..8; never wraps past 8.
- Edges seen in IDLE are ignored.

## Timing
- Reset (any time, including mid-frame) forces asynchronously: state IDLE, rx_data = 0, done = 0, tx_load = 0, busy = 0, MISO = 0, bit_cnt = 0, shift registers = 0, synchronizers = 0 (sclk sync flops reset to 0).
- Pin-to-action latency: SYNC_STAGES + 1 clk from an SCLK pin edge to the rx_shift/tx_shift update. MISO changes on that same clk edge.
- done, tx_load and rx_data update on the same clk edge, SYNC_STAGES + 1 clk after the 8th sample edge.
- First MISO bit (tx_data[7]) is valid SYNC_STAGES + 1 clk after the SS_n falling pin edge. The master must leave at least that long before its first sample.
- Requirements on SCLK and SS_n:
  - SCLK high and low phases must each be ≥ SYNC_STAGES + 2 clk. The team's master gives 50 clk per phase.
  - SS_n setup to first SCLK edge ≥ SYNC_STAGES + 2 clk.
- MOSI must be stable around the sample edge for ≥ SYNC_STAGES + 1 clk. MOSI passes through the same synchronizer depth as SCLK, so both arrive aligned.
- tx_data must be valid in the cycle tx_load asserts. User updates tx_data after a tx_load pulse for the following byte.

## Test plan
- Mode 0 (cpol=0, cpha=0), tx_data=0xA5, master sends 0x3C, 50-clk half-period → rx_data=0x3C with one done pulse; master receives 0xA5; tx_load pulses twice (select, completion).
- Modes 1, 2, 3, each with tx=0x81, master sends 0x7E → rx_data=0x7E, master receives 0x81; in CPHA=1 MISO shows no spurious shift on the first leading edge.
- Two bytes under one SS_n low: master sends 0x12 then 0x34, slave tx_data 0xF0 then 0x0F (updated after first tx_load) → done twice with rx_data 0x12 then 0x34; master receives 0xF0, 0x0F.
- SS_n deasserted after 5 SCLK cycles → no done, rx_data keeps prior value, busy falls, MISO=0. The next full frame of 0x55 yields rx_data=0x55.
- reset pulsed after 3 bits of a frame → all outputs at reset values immediately. After release, a new frame of 0xC3 gives rx_data=0xC3 with no residue from the aborted bits.
- SS_n rises in the same clk as 8th-sample completion → done=1 with the correct byte, then IDLE.
